uart_tx_sched: RTL and testbench

Shares the single `uart_tx` transmitter between two byte producers (port 0: CPU memory-mapped UART data register; port 1: debug/status dumper). It arbitrates the two valid/ready byte streams round-robin into a small shared FIFO. A sequencer then drains the FIFO into `uart_tx` using that block's level-held `start_tx`/`tx_done` handshake. It sits between the peripheral bus logic and `uart_tx` in the MCU top level.

---
 rtl/uart_tx_sched_if.sv | 30 +++
 rtl/uart_tx_sched.sv | 141 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Byte-producer / uart_tx handshake bundle seen by the transmit scheduler.
// master = environment side (producers, flush, uart_tx); slave = the scheduler.
interface uart_tx_sched_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             req0_valid;
    logic [7:0]       req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_data;
    logic             req1_ready;
    logic             flush;
    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_done;
    logic [LVL_W-1:0] fifo_level;
    logic             busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, flush, tx_done,
        input  req0_ready, req1_ready, tx_start, tx_byte, fifo_level, busy
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, flush, tx_done,
        output req0_ready, req1_ready, tx_start, tx_byte, fifo_level, busy
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin merge of two byte streams into a shared FIFO drained into uart_tx; push->tx_start 2 cycles.
// Readys drop while the FIFO is full or during flush/rst; tx_start/tx_done is a level-held handshake.
module uart_tx_sched #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_sched_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        SEND    = 3'b010,
        RELEASE = 3'b100
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             rr_q, rr_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_byte_q, tx_byte_d;

    logic             full;
    logic             blocked;
    logic             grant0;
    logic             grant1;
    logic             push;
    logic             pop;
    logic [7:0]       push_data;

    // Arbitration: rr only breaks ties, but any grant moves it to the other port.
    always_comb begin
        full      = (level_q == LVL_W'(DEPTH));
        blocked   = full | rst | bus.flush;
        grant0    = ~blocked & bus.req0_valid & (~bus.req1_valid | ~rr_q);
        grant1    = ~blocked & bus.req1_valid & (~bus.req0_valid |  rr_q);
        push      = grant0 | grant1;
        push_data = grant0 ? bus.req0_data : bus.req1_data;
        rr_d      = rr_q;
        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_byte_d  = tx_byte_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((level_q != '0) && !bus.flush) begin
                    pop        = 1'b1;
                    tx_byte_d  = mem_q[head_q];
                    tx_start_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bus.tx_done) begin
                    tx_start_d = 1'b0;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // Flush never coincides with push or pop: readys and the IDLE pop both exclude it.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (!push && pop) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            rr_q       <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
            rr_q       <= rr_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.fifo_level = level_q;
    assign bus.busy       = (level_q != '0) | (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: uart_tx stand-in, queue-based reference model, vector table and directed sequences.
module tb_uart_tx_sched;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.DEPTH(DEPTH)) bus ();
    uart_tx_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    // uart_tx stand-in
    logic       stall;
    int         frame_len;
    int         ucnt;
    logic [7:0] sent[$];

    // Reference model: queue of waiting bytes plus the byte on the wire
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic       m_rr, m_start, m_wait;
    logic [7:0] m_byte;

    logic       obs_r0, obs_r1;
    logic [7:0] n0, n1;
    int         k;
    logic [7:0] rr_exp [4];

    typedef struct {
        logic v0;
        logic v1;
        logic fl;
        logic r0;
        logic r1;
        int   lvl;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Runs at the falling edge: one-cycle tx_done pulse after frame_len+1 cycles of tx_start.
    task automatic uart_step();
        if (rst) begin
            bus.tx_done = 1'b0;
            ucnt = 0;
        end else if (bus.tx_done) begin
            bus.tx_done = 1'b0;
        end else if (bus.tx_start && !stall) begin
            if (ucnt >= frame_len) begin
                bus.tx_done = 1'b1;
                ucnt = 0;
                sent.push_back(bus.tx_byte);
            end else begin
                ucnt++;
            end
        end else if (!bus.tx_start) begin
            ucnt = 0;
        end
    endtask

    task automatic model_edge(input logic g0, input logic g1);
        if (rst) begin
            m_q.delete();
            m_rr = 1'b0;
            m_start = 1'b0;
            m_wait = 1'b0;
            m_byte = 8'h00;
        end else begin
            if (!m_start && !m_wait) begin
                if (m_q.size() != 0 && !bus.flush) begin
                    m_byte = m_q.pop_front();
                    m_start = 1'b1;
                end
            end else if (m_start) begin
                if (bus.tx_done) begin
                    m_start = 1'b0;
                    m_wait = 1'b1;
                    m_sent.push_back(m_byte);
                end
            end else if (!bus.tx_done) begin
                m_wait = 1'b0;
            end
            if (bus.flush) m_q.delete();
            if (g0) begin
                m_q.push_back(bus.req0_data);
                m_rr = 1'b1;
            end else if (g1) begin
                m_q.push_back(bus.req1_data);
                m_rr = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, check readys, model the edge, check registered outputs.
    task automatic step(input logic r, input logic fl, input logic v0, input logic v1,
                        input logic [7:0] d0, input logic [7:0] d1);
        logic g0, g1, blk;
        rst = r;
        bus.flush = fl;
        bus.req0_valid = v0;
        bus.req0_data = d0;
        bus.req1_valid = v1;
        bus.req1_data = d1;
        uart_step();
        #1;
        blk = r || fl || (m_q.size() == DEPTH);
        g0 = !blk && v0 && (!v1 || !m_rr);
        g1 = !blk && v1 && (!v0 || m_rr);
        obs_r0 = bus.req0_ready;
        obs_r1 = bus.req1_ready;
        chk("req0_ready", obs_r0, g0);
        chk("req1_ready", obs_r1, g1);
        @(posedge clk);
        model_edge(g0, g1);
        @(negedge clk);
        chk("tx_start", bus.tx_start, m_start);
        chk("tx_byte", bus.tx_byte, m_byte);
        chk("fifo_level", bus.fifo_level, m_q.size());
        chk("busy", bus.busy, (m_q.size() != 0) || m_start || m_wait);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && bus.busy; i++) idle();
        chk(name, bus.busy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        sent.delete();
        m_sent.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data = 8'h00;
        bus.tx_done = 1'b0;
        stall = 1'b0;
        frame_len = 4;
        ucnt = 0;
        m_rr = 1'b0;
        m_start = 1'b0;
        m_wait = 1'b0;
        m_byte = 8'h00;
        @(negedge clk);

        // Reset state, with both producers asserting valid
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 8'hBB);
        chk("rst_r0", obs_r0, 1'b0);
        chk("rst_r1", obs_r1, 1'b0);
        chk("rst_tx_start", bus.tx_start, 1'b0);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_busy", bus.busy, 1'b0);

        // Single push: tx_start two cycles after valid
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 8'h00);
        chk("single_ready", obs_r0, 1'b1);
        chk("single_lvl1", bus.fifo_level, 1);
        chk("single_start_early", bus.tx_start, 1'b0);
        idle();
        chk("single_start", bus.tx_start, 1'b1);
        chk("single_byte", bus.tx_byte, 8'h41);
        chk("single_lvl0", bus.fifo_level, 0);
        drain("single_busy");
        chk("single_sent_n", sent.size(), 1);
        if (sent.size() > 0) chk("single_sent", sent[0], 8'h41);

        // Simultaneous push and pop at level 1
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h51, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h52);
        chk("pp_ready", obs_r1, 1'b1);
        chk("pp_level", bus.fifo_level, 1);
        chk("pp_byte", bus.tx_byte, 8'h51);
        drain("pp_busy");
        chk("pp_sent_n", sent.size(), 3);
        if (sent.size() == 3) chk("pp_sent_last", sent[2], 8'h52);

        // Round robin with both ports streaming
        do_reset();
        frame_len = 2;
        n0 = 8'h10;
        n1 = 8'h20;
        rr_exp = '{8'h10, 8'h20, 8'h11, 8'h21};
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, n0, n1);
            if (i == 0) chk("rr_first_grant", obs_r0, 1'b1);
            if (obs_r0) n0++;
            if (obs_r1) n1++;
        end
        drain("rr_busy");
        chk("rr_sent_enough", sent.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < sent.size(); i++)
            chk($sformatf("rr_order%0d", i), sent[i], rr_exp[i]);

        // Full FIFO with uart_tx stalled; pointers wrap past index 3
        do_reset();
        stall = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h60 + k), 8'h00);
            if (obs_r0) k++;
        end
        chk("full_level", bus.fifo_level, 4);
        chk("full_ready", obs_r0, 1'b0);
        chk("full_in_send", bus.tx_start, 1'b1);
        chk("full_accepted5", k, 5);
        stall = 1'b0;
        for (int i = 0; i < 200 && k < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h60 + k), 8'h00);
            if (obs_r0) k++;
        end
        chk("full_accepted6", k, 6);
        drain("full_busy");
        chk("full_sent_n", sent.size(), 6);
        for (int i = 0; i < sent.size() && i < 6; i++)
            chk($sformatf("full_sent%0d", i), sent[i], 8'(8'h60 + i));

        // Flush with one byte in flight and three queued
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'(8'h70 + i));
        chk("fl_level3", bus.fifo_level, 3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h7F);
        chk("fl_ready", obs_r1, 1'b0);
        chk("fl_level0", bus.fifo_level, 0);
        chk("fl_inflight", bus.tx_start, 1'b1);
        stall = 1'b0;
        drain("fl_busy");
        chk("fl_sent_n", sent.size(), 1);
        if (sent.size() > 0) chk("fl_sent", sent[0], 8'h70);

        // Arbitration vector table from reset, uart_tx stalled after the first pop
        do_reset();
        stall = 1'b1;
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4},
            '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1}
        };
        for (int i = 0; i < 9; i++) begin
            step(1'b0, tbl[i].fl, tbl[i].v0, tbl[i].v1, 8'(8'h10 + i), 8'(8'h20 + i));
            chk($sformatf("tbl%0d_r0", i), obs_r0, tbl[i].r0);
            chk($sformatf("tbl%0d_r1", i), obs_r1, tbl[i].r1);
            chk($sformatf("tbl%0d_lvl", i), bus.fifo_level, tbl[i].lvl);
        end

        // Reset while a byte is in SEND
        chk("mid_pre_send", bus.tx_start, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("mid_rst_start", bus.tx_start, 1'b0);
        chk("mid_rst_level", bus.fifo_level, 0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        sent.delete();
        m_sent.delete();
        stall = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 8'h00);
        drain("mid_busy");
        chk("mid_sent_n", sent.size(), 1);
        if (sent.size() > 0) chk("mid_sent", sent[0], 8'h99);

        // Randomized traffic against the reference model
        do_reset();
        frame_len = $urandom_range(0, 5);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) stall = ~stall;
            step($urandom_range(0, 499) == 0, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40,
                 8'($urandom), 8'($urandom));
        end
        stall = 1'b0;
        drain("rand_busy");
        chk("rand_sent_n", sent.size(), m_sent.size());
        for (int i = 0; i < sent.size() && i < m_sent.size(); i++)
            chk("rand_sent", sent[i], m_sent[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
